// File: rtl/pwm_counter.sv
`default_nettype none
//============================================================================
// Module   : pwm_counter
// Purpose  : Prescaled up/down PWM timebase with live period reload and
//            single-cycle overflow/underflow pulses.
// Options  : PWM_COUNTER_ONESHOT_EN adds a one-shot (stop after first wrap).
// Revision : 1.0 - initial release
//============================================================================
module pwm_counter #(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [WIDTH-1:0]   period,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               upnotdown,
    input  logic               count_reset,
`ifdef PWM_COUNTER_ONESHOT_EN
    input  logic               oneshot,
`endif
    output logic [WIDTH-1:0]   count_val,
    output logic               ovf_pulse,
    output logic               udf_pulse
);

    logic [WIDTH-1:0]   r_count;
    logic [PRESC_W-1:0] r_psc_cnt;
    logic               r_ovf;
    logic               r_udf;

    logic w_active;
    logic w_tick;
    logic w_wrap_up;
    logic w_wrap_dn;

`ifdef PWM_COUNTER_ONESHOT_EN
    logic r_run;
    logic r_en_d;
    logic w_run_now;

    // An en rising edge re-arms the one-shot in the same cycle it is seen.
    assign w_run_now = r_run | (en & ~r_en_d);
    assign w_active  = en & (w_run_now | ~oneshot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= 1'b1;
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= en;
            if (count_reset) begin
                r_run <= 1'b1;
            end else if (w_tick && (w_wrap_up || w_wrap_dn) && oneshot) begin
                r_run <= 1'b0;
            end else begin
                r_run <= w_run_now;
            end
        end
    end
`else
    assign w_active = en;
`endif

    // >= rather than == so a lowered prescale/period takes effect at once.
    assign w_tick    = w_active && (r_psc_cnt >= prescale);
    assign w_wrap_up = upnotdown && (r_count >= period);
    assign w_wrap_dn = !upnotdown && (r_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_psc_cnt <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else if (count_reset) begin
            r_count   <= '0;
            r_psc_cnt <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            if (w_tick) begin
                r_psc_cnt <= '0;
                if (w_wrap_up) begin
                    r_count <= '0;
                    r_ovf   <= 1'b1;
                end else if (w_wrap_dn) begin
                    r_count <= period;
                    r_udf   <= 1'b1;
                end else if (upnotdown) begin
                    r_count <= r_count + 1'b1;
                end else begin
                    r_count <= r_count - 1'b1;
                end
            end else if (w_active) begin
                r_psc_cnt <= r_psc_cnt + 1'b1;
            end
        end
    end

    assign count_val = r_count;
    assign ovf_pulse = r_ovf;
    assign udf_pulse = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_pwm_counter.sv
`default_nettype none
//============================================================================
// Module   : tb_pwm_counter
// Purpose  : Randomised scoreboard bench for pwm_counter against a
//            behavioural timebase model.
// Revision : 1.0 - initial release
//============================================================================
module tb_pwm_counter;

    localparam int WIDTH   = 4;
    localparam int PRESC_W = 3;
`ifdef PWM_COUNTER_ONESHOT_EN
    localparam bit ONESHOT_EN = 1'b1;
`else
    localparam bit ONESHOT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic [WIDTH-1:0]   period = '0;
    logic [PRESC_W-1:0] prescale = '0;
    logic               upnotdown = 1'b1;
    logic               count_reset = 1'b0;
`ifdef PWM_COUNTER_ONESHOT_EN
    logic               oneshot = 1'b0;
`endif
    logic [WIDTH-1:0]   count_val;
    logic               ovf_pulse;
    logic               udf_pulse;

    pwm_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .period      (period),
        .prescale    (prescale),
        .upnotdown   (upnotdown),
        .count_reset (count_reset),
`ifdef PWM_COUNTER_ONESHOT_EN
        .oneshot     (oneshot),
`endif
        .count_val   (count_val),
        .ovf_pulse   (ovf_pulse),
        .udf_pulse   (udf_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit ovf;
        bit udf;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: the timebase is a position in 0..period plus a
    // phase within the current prescale interval.
    int m_cnt = 0;
    int m_phase = 0;
    bit m_run = 1'b1;
    bit m_en_prev = 1'b0;

    // Monitor: every cycle the DUT presents a new count and pulse pair.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (int'(count_val) != e.cnt || ovf_pulse != e.ovf || udf_pulse != e.udf) begin
                    n_fail++;
                    $display("FAIL timebase @%0t: got cnt=%0d ovf=%0b udf=%0b, expected cnt=%0d ovf=%0b udf=%0b",
                             $time, count_val, ovf_pulse, udf_pulse, e.cnt, e.ovf, e.udf);
                end
            end
        end
    end

    task automatic step(input bit rn, input bit e, input int per, input int psc,
                        input bit up, input bit cr, input bit os);
        exp_t x;
        bit   may_run;
        bit   wrapped;
        @(negedge clk);
        rst_n       = rn;
        en          = e;
        period      = per[WIDTH-1:0];
        prescale    = psc[PRESC_W-1:0];
        upnotdown   = up;
        count_reset = cr;
`ifdef PWM_COUNTER_ONESHOT_EN
        oneshot     = os;
`endif
        x.ovf = 1'b0;
        x.udf = 1'b0;
        if (!rn) begin
            m_cnt = 0; m_phase = 0; m_run = 1'b1; m_en_prev = 1'b0;
        end else if (cr) begin
            m_cnt = 0; m_phase = 0; m_run = 1'b1; m_en_prev = e;
        end else begin
            if (e && !m_en_prev) m_run = 1'b1;
            may_run = m_run || !(os && ONESHOT_EN);
            wrapped = 1'b0;
            if (e && may_run) begin
                if (m_phase < psc) begin
                    m_phase++;
                end else begin
                    m_phase = 0;
                    if (up) begin
                        if (m_cnt >= per) begin m_cnt = 0; x.ovf = 1'b1; wrapped = 1'b1; end
                        else m_cnt++;
                    end else begin
                        if (m_cnt == 0) begin m_cnt = per; x.udf = 1'b1; wrapped = 1'b1; end
                        else m_cnt--;
                    end
                end
            end
            if (wrapped && os && ONESHOT_EN) m_run = 1'b0;
            m_en_prev = e;
        end
        x.cnt = m_cnt;
        q.push_back(x);
    endtask

    initial begin
        int per;
        int psc;
        bit up;
        bit e;
        bit os;

        // Reset state
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 3, 0, 1, 0, 0);

        // Plain up count, period 3
        for (int i = 0; i < 12; i++) step(1, 1, 3, 0, 1, 0, 0);

        // Prescaled up count with a freeze mid-sequence
        step(1, 1, 2, 2, 1, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 2, 2, 1, 0, 0);
        for (int i = 0; i < 5; i++)  step(1, 0, 2, 2, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 2, 2, 1, 0, 0);

        // Down count, then period 0
        step(1, 1, 4, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 4, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)  step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)  step(1, 1, 0, 0, 1, 0, 0);

        // count_reset with en high and with en low
        step(1, 1, 9, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 9, 0, 1, 0, 0);
        step(1, 1, 9, 0, 1, 1, 0);
        step(1, 1, 9, 0, 1, 0, 0);
        step(1, 0, 9, 0, 1, 0, 0);
        step(1, 0, 9, 0, 1, 1, 0);
        step(1, 0, 9, 0, 1, 0, 0);

        // Live period lowered below count, live prescale lowered below phase
        step(1, 1, 10, 0, 1, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 10, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 3, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 3, 5, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 3, 1, 1, 0, 0);

        // All-ones period wraps via the compare
        for (int i = 0; i < 20; i++) step(1, 1, 15, 0, 1, 0, 0);

`ifdef PWM_COUNTER_ONESHOT_EN
        step(1, 1, 2, 0, 1, 1, 1);
        for (int i = 0; i < 6; i++) step(1, 1, 2, 0, 1, 0, 1);
        step(1, 0, 2, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 1, 2, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 2, 0, 0, 0, 1);
`endif

        // Randomised traffic
        per = 5; psc = 1; up = 1'b1; os = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 5)
                per = ($urandom_range(3) == 0) ? 15 : int'($urandom_range(6));
            if ($urandom_range(99) < 5)
                psc = ($urandom_range(4) == 0) ? 7 : int'($urandom_range(3));
            if ($urandom_range(99) < 3) up = ~up;
            if ($urandom_range(99) < 2) os = ~os;
            e = ($urandom_range(99) < 88);
            step(($urandom_range(999) < 3) ? 1'b0 : 1'b1, e, per, psc, up,
                 ($urandom_range(99) < 3), os);
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
